rename_reg_file: RTL
====================

RENAME_REG_FILE -- requirements
Module: rename_reg_file

Interface
REQ-001 SHALL have parameter N_LOGIC, default 256, number of logical registers.
REQ-002 SHALL have parameter LOGIC_W, default 8, logical index width, equal to clog2(N_LOGIC).
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter TAG_W, default 16, physical tag width, at most DATA_W.
REQ-005 SHALL have parameter N_READ, default 2, number of source read ports.
REQ-006 SHALL have parameter N_WB, default 2, number of writeback (complete) ports.
REQ-007 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port flash, input, 1, pipeline flush.
REQ-010 SHALL have ports dest_en and dest_logic, inputs, 1 and LOGIC_W, rename-allocate request.
REQ-011 SHALL have port src[N_READ], input, LOGIC_W each, source indices.
REQ-012 SHALL have ports wb_en[N_WB], wb_logic[N_WB], wb_tag[N_WB] and wb_data[N_WB], inputs, widths 1/LOGIC_W/TAG_W/DATA_W, completion results.
REQ-013 SHALL have ports commit_en, commit_logic, commit_tag and commit_data, inputs, widths 1/LOGIC_W/TAG_W/DATA_W, in-order retirement.
REQ-014 SHALL have ports read_valid[N_READ] and read_payload[N_READ], outputs, widths 1 and DATA_W; payload carries data when valid, otherwise the zero-extended tag.
REQ-015 SHALL have port dest_tag, output, TAG_W, tag assigned to the current dest_en.

Function
REQ-016 Each entry SHALL hold: place (0 = architectural, 1 = physical), arch_data, phys_valid, phys_data and phys_tag.
REQ-017 dest_tag SHALL be the tag counter value, combinationally, with no added latency.
REQ-018 On dest_en, the entry at dest_logic SHALL set place to 1, phys_valid to 0 and phys_tag to dest_tag, and the counter SHALL increment modulo 2^TAG_W (wraps from all-ones to 0).
REQ-019 Writeback port k SHALL be accepted only when all hold: wb_en[k]; entry place is 1; phys_valid is 0; phys_tag equals wb_tag[k].
REQ-020 An accepted writeback SHALL set phys_valid to 1 and phys_data to wb_data[k], unless dest_en targets the same wb_logic in that cycle, in which case the dest_en update wins.
REQ-021 If two accepted writebacks target one entry, the lowest port index SHALL win.
REQ-022 On commit_en, arch_data of commit_logic SHALL be written with commit_data.
REQ-023 If, in addition, place is 1 and phys_tag equals commit_tag, place SHALL return to 0, unless dest_en targets the same index in that cycle.
REQ-024 Read port j SHALL be registered, with 1-cycle latency, using this priority:
 - an accepted writeback whose wb_logic equals src[j] gives valid=1 and its data (lowest port first);
 - otherwise, with place 1, valid=phys_valid and payload=phys_data or phys_tag;
 - otherwise valid=1 and payload=arch_data.
REQ-025 Reads SHALL see pre-edge state for dest_en and commit in the same cycle (no dest/commit bypass).
REQ-026 A writeback with a stale tag, or one targeting a place=0 entry, SHALL be silently dropped.
REQ-027 When flash is high:
 - counter goes to 0;
 - every place goes to 0;
 - every read_valid goes to 0;
 - dest_en and wb are ignored;
 - commit is still applied to arch_data.
REQ-028 The block SHALL never back-pressure; there are no reject/ready outputs.

Reset
REQ-029 While reset_n is low, the following SHALL hold immediately and asynchronously:
 - every place, phys_valid, arch_data, phys_data and phys_tag is 0;
 - the counter is 0;
 - read_valid and read_payload are all 0;
 - dest_tag is 0.
REQ-030 The first rising edge after reset_n deasserts SHALL behave as a normal cycle.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight renames with no residual state.

Structure
REQ-032 Package rename_pkg SHALL hold the default parameter constants and the entry struct typedef.
REQ-033 Sub-module rf_wb_select SHALL provide the per-read-port lowest-index writeback match/bypass priority selector, instanced N_READ times.
REQ-034 The entry array SHALL be flip-flops, not inferred RAM, to support the parallel flash clear.

Verification
REQ-035 Reset, then read src0=5: the next cycle gives read_valid=1, payload=0.
REQ-036 dest_en on r3 gives dest_tag=0; the next cycle reading r3 gives valid=0, payload=0x0000; a second dest_en gives dest_tag=1.
REQ-037 Writeback r3 with tag 0, data 0xDEADBEEF, while src1=3 in the same cycle: the next cycle gives read_valid=1, payload=0xDEADBEEF (bypass).
REQ-038 Rename r7 twice (tags 4 then 5), then writeback tag 4: it is dropped and r7 stays invalid; writeback tag 5 with data 0x11 then reads 0x11.
REQ-039 Commit r7, tag 5, data 0x11: place returns to 0 and r7 reads arch 0x11; a commit with tag 4 leaves place unchanged.
REQ-040 Counter at 0xFFFF then dest_en gives a wrap to 0; flash with commit r2=0x22 in the same cycle clears all renames, the counter reads 0, and r2 reads 0x22.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared constants and entry layout for the rename register file.
// Default parameter values plus the per-entry state record.
package rename_pkg;

   localparam int DEF_N_LOGIC = 256;
   localparam int DEF_LOGIC_W = 8;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TAG_W   = 16;
   localparam int DEF_N_READ  = 2;
   localparam int DEF_N_WB    = 2;

   typedef struct packed {
      logic                  place;
      logic [DEF_DATA_W-1:0] arch_data;
      logic                  phys_valid;
      logic [DEF_DATA_W-1:0] phys_data;
      logic [DEF_TAG_W-1:0]  phys_tag;
   } entry_t;

endpackage

// File: rtl/rf_wb_select.sv
// Picks the lowest-index accepted writeback that targets one source index.
// Gives the hit flag and the bypass data for one read port.
module rf_wb_select
   import rename_pkg::*;
#(
   parameter int LOGIC_W = DEF_LOGIC_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int N_WB    = DEF_N_WB
) (
   input  logic [LOGIC_W-1:0] i_src,
   input  logic               i_wb_acc   [N_WB],
   input  logic [LOGIC_W-1:0] i_wb_logic [N_WB],
   input  logic [DATA_W-1:0]  i_wb_data  [N_WB],
   output logic               o_hit,
   output logic [DATA_W-1:0]  o_data
);

   // Scan high to low so the lowest matching port is written last.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      for (int k = N_WB - 1; k >= 0; k--) begin
         if (i_wb_acc[k] && (i_wb_logic[k] == i_src)) begin
            o_hit  = 1'b1;
            o_data = i_wb_data[k];
         end
      end
   end

endmodule

// File: rtl/rename_reg_file.sv
// Rename register file: tag allocation, writeback capture, commit and
// registered source reads with same-cycle writeback bypass.
module rename_reg_file
   import rename_pkg::*;
#(
   parameter int N_LOGIC = DEF_N_LOGIC,
   parameter int LOGIC_W = DEF_LOGIC_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TAG_W   = DEF_TAG_W,
   parameter int N_READ  = DEF_N_READ,
   parameter int N_WB    = DEF_N_WB
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               flash,
   input  logic               dest_en,
   input  logic [LOGIC_W-1:0] dest_logic,
   input  logic [LOGIC_W-1:0] src          [N_READ],
   input  logic               wb_en        [N_WB],
   input  logic [LOGIC_W-1:0] wb_logic     [N_WB],
   input  logic [TAG_W-1:0]   wb_tag       [N_WB],
   input  logic [DATA_W-1:0]  wb_data      [N_WB],
   input  logic               commit_en,
   input  logic [LOGIC_W-1:0] commit_logic,
   input  logic [TAG_W-1:0]   commit_tag,
   input  logic [DATA_W-1:0]  commit_data,
   output logic               read_valid   [N_READ],
   output logic [DATA_W-1:0]  read_payload [N_READ],
   output logic [TAG_W-1:0]   dest_tag
);

   typedef struct packed {
      logic              place;
      logic [DATA_W-1:0] arch_data;
      logic              phys_valid;
      logic [DATA_W-1:0] phys_data;
      logic [TAG_W-1:0]  phys_tag;
   } ent_t;

   ent_t              r_ent      [N_LOGIC];
   ent_t              w_nxt      [N_LOGIC];
   logic [TAG_W-1:0]  r_ctr;
   logic              w_dest_go;
   logic              w_acc      [N_WB];
   logic              w_hit      [N_READ];
   logic [DATA_W-1:0] w_hdat     [N_READ];
   logic              w_rd_valid [N_READ];
   logic [DATA_W-1:0] w_rd_pay   [N_READ];
   logic              r_rd_valid [N_READ];
   logic [DATA_W-1:0] r_rd_pay   [N_READ];

   assign dest_tag     = r_ctr;
   assign w_dest_go    = dest_en & ~flash;
   assign read_valid   = r_rd_valid;
   assign read_payload = r_rd_pay;

   always_comb begin
      for (int k = 0; k < N_WB; k++) begin
         w_acc[k] = wb_en[k] & ~flash
                  & r_ent[wb_logic[k]].place
                  & ~r_ent[wb_logic[k]].phys_valid
                  & (r_ent[wb_logic[k]].phys_tag == wb_tag[k]);
      end
   end

   // Update order encodes priority: commit, then writeback, then dest.
   always_comb begin
      w_nxt = r_ent;
      if (commit_en) begin
         w_nxt[commit_logic].arch_data = commit_data;
         if (r_ent[commit_logic].place &&
             (r_ent[commit_logic].phys_tag == commit_tag)) begin
            w_nxt[commit_logic].place = 1'b0;
         end
      end
      for (int k = N_WB - 1; k >= 0; k--) begin
         if (w_acc[k]) begin
            w_nxt[wb_logic[k]].phys_valid = 1'b1;
            w_nxt[wb_logic[k]].phys_data  = wb_data[k];
         end
      end
      if (w_dest_go) begin
         w_nxt[dest_logic].place      = 1'b1;
         w_nxt[dest_logic].phys_valid = 1'b0;
         w_nxt[dest_logic].phys_tag   = r_ctr;
      end
      if (flash) begin
         for (int i = 0; i < N_LOGIC; i++) begin
            w_nxt[i].place = 1'b0;
         end
      end
   end

   for (genvar j = 0; j < N_READ; j++) begin : g_rd
      rf_wb_select #(
         .LOGIC_W (LOGIC_W),
         .DATA_W  (DATA_W),
         .N_WB    (N_WB)
      ) u_sel (
         .i_src      (src[j]),
         .i_wb_acc   (w_acc),
         .i_wb_logic (wb_logic),
         .i_wb_data  (wb_data),
         .o_hit      (w_hit[j]),
         .o_data     (w_hdat[j])
      );
   end

   always_comb begin
      for (int j = 0; j < N_READ; j++) begin
         w_rd_valid[j] = 1'b0;
         w_rd_pay[j]   = '0;
         if (flash) begin
            w_rd_valid[j] = 1'b0;
         end else if (w_hit[j]) begin
            w_rd_valid[j] = 1'b1;
            w_rd_pay[j]   = w_hdat[j];
         end else if (r_ent[src[j]].place) begin
            w_rd_valid[j] = r_ent[src[j]].phys_valid;
            w_rd_pay[j]   = r_ent[src[j]].phys_valid ?
                            r_ent[src[j]].phys_data :
                            DATA_W'(r_ent[src[j]].phys_tag);
         end else begin
            w_rd_valid[j] = 1'b1;
            w_rd_pay[j]   = r_ent[src[j]].arch_data;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ent      <= '{default: '0};
         r_ctr      <= '0;
         r_rd_valid <= '{default: 1'b0};
         r_rd_pay   <= '{default: '0};
      end else begin
         r_ent      <= w_nxt;
         r_rd_valid <= w_rd_valid;
         r_rd_pay   <= w_rd_pay;
         if (flash) begin
            r_ctr <= '0;
         end else if (dest_en) begin
            r_ctr <= r_ctr + TAG_W'(1);
         end
      end
   end

endmodule
